// File: rtl/pulp_io_event_queue.sv
// -----------------------------------------------------------------------------
// pulp_io_event_queue
//
// Purpose:
//   Collects single-cycle event pulses from N_CH peripheral channels with
//   N_EVT event lines each. Every pulse is latched in a per-source pending
//   bit. A round-robin arbiter then picks one pending source per cycle and
//   pushes its flat ID (ch*N_EVT+evt) into a FIFO. The FIFO drains over a
//   valid/ready stream toward the SoC event unit.
//
// Optional feature:
//   Define PULP_IO_EVT_TIMESTAMP_EN to enable timestamping. A free-running
//   TS_WIDTH counter is sampled into each FIFO entry at its push edge and is
//   presented on evt_ts_o together with the head entry. Without the macro
//   there is no counter and no timestamp storage, and evt_ts_o is tied to 0.
//
// Ports:
//   sys_clk_i     in   1              single clock
//   sys_rst_ni    in   1              asynchronous active-low reset
//   events_i      in   [N_CH][N_EVT]  event pulses, flat index ch*N_EVT+evt
//   evt_mask_i    in   N_SRC          1 = capture enabled for that source
//   clear_i       in   1              synchronous flush (highest priority)
//   evt_valid_o   out  1              FIFO head valid
//   evt_id_o      out  ID_W           flat source ID at FIFO head (0 if empty)
//   evt_ts_o      out  TS_WIDTH       timestamp at FIFO head (0 if empty)
//   evt_ready_i   in   1              consumer accepts the head
//   fifo_level_o  out  LVL_W          current FIFO occupancy
//   overflow_o    out  1              sticky lost-event flag
// -----------------------------------------------------------------------------
module pulp_io_event_queue #(
   parameter  int N_CH       = 32,
   parameter  int N_EVT      = 4,
   parameter  int FIFO_DEPTH = 8,
   parameter  int TS_WIDTH   = 16,
   localparam int N_SRC      = N_CH * N_EVT,
   localparam int ID_W       = $clog2(N_SRC),
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                              sys_clk_i,
   input  logic                              sys_rst_ni,
   input  logic [N_CH-1:0][N_EVT-1:0]        events_i,
   input  logic [N_SRC-1:0]                  evt_mask_i,
   input  logic                              clear_i,
   output logic                              evt_valid_o,
   output logic [ID_W-1:0]                   evt_id_o,
   output logic [TS_WIDTH-1:0]               evt_ts_o,
   input  logic                              evt_ready_i,
   output logic [LVL_W-1:0]                  fifo_level_o,
   output logic                              overflow_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // Index of the lowest set bit of v (0 when v is empty; callers check |v).
   function automatic logic [ID_W-1:0] f_lowest_set(input logic [N_SRC-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [N_SRC-1:0]   r_pending;
   logic [ID_W-1:0]    r_rr_ptr;
   logic               r_overflow;
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [LVL_W-1:0]   r_level;
   logic [ID_W-1:0]    r_mem_id [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   logic [N_SRC-1:0]   w_evt;
   logic [N_SRC-1:0]   w_new;
   logic [N_SRC-1:0]   w_hi_mask;
   logic [N_SRC-1:0]   w_pend_hi;
   logic [N_SRC-1:0]   w_grant_oh;
   logic [ID_W-1:0]    w_grant_id;
   logic               w_grant;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_can_push;
   logic               w_lost;

   // The packed 2-D port flattens naturally to index ch*N_EVT+evt.
   assign w_evt   = events_i;
   assign w_new   = w_evt & evt_mask_i;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_pop   = !w_empty && evt_ready_i;

   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign w_can_push = !w_full || w_pop;

   // Round-robin search: first look at pending sources at or above rr_ptr;
   // if none, wrap around and take the lowest pending source overall.
   always_comb begin
      w_hi_mask = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_hi_mask[i] = (ID_W'(i) >= r_rr_ptr);
      end
      w_pend_hi  = r_pending & w_hi_mask;
      w_grant_id = (|w_pend_hi) ? f_lowest_set(w_pend_hi) : f_lowest_set(r_pending);
   end

   assign w_grant    = w_can_push && (|r_pending) && !clear_i;
   assign w_push     = w_grant;
   assign w_grant_oh = w_grant ? (N_SRC'(1) << w_grant_id) : '0;

   // A pulse is lost only if its pending bit is still occupied after this
   // cycle's grant; a pulse on the granted source simply re-arms the bit.
   assign w_lost = |(w_new & r_pending & ~w_grant_oh);

   // ---------------------------------------------------------------------------
   // Pending bits, round-robin pointer, overflow flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         r_pending  <= '0;
         r_rr_ptr   <= '0;
         r_overflow <= 1'b0;
      end else if (clear_i) begin
         r_pending  <= '0;
         r_rr_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_grant_oh) | w_new;
         if (w_grant) begin
            r_rr_ptr <= (w_grant_id == ID_W'(N_SRC - 1)) ? '0 : w_grant_id + ID_W'(1);
         end
         if (w_lost) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         // Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // FIFO payload storage; contents are only observed through the valid-gated
   // head, so no reset is needed here.
   always_ff @(posedge sys_clk_i) begin
      if (w_push) begin
         r_mem_id[r_wptr] <= w_grant_id;
      end
   end

   // ---------------------------------------------------------------------------
   // Output stream
   // ---------------------------------------------------------------------------
   assign evt_valid_o  = !w_empty;
   assign evt_id_o     = w_empty ? '0 : r_mem_id[r_rptr];
   assign fifo_level_o = r_level;
   assign overflow_o   = r_overflow;

`ifdef PULP_IO_EVT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] r_ts;
   logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];

   // Free-running time base; deliberately not affected by clear_i.
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + TS_WIDTH'(1);
      end
   end

   // Each entry records the counter value present at its push edge.
   always_ff @(posedge sys_clk_i) begin
      if (w_push) begin
         r_mem_ts[r_wptr] <= r_ts;
      end
   end

   assign evt_ts_o = w_empty ? '0 : r_mem_ts[r_rptr];
`else
   assign evt_ts_o = '0;
`endif

endmodule

// File: tb/tb_pulp_io_event_queue.sv
// -----------------------------------------------------------------------------
// Testbench for pulp_io_event_queue.
// A queue-based reference model is advanced on every rising edge and compared
// against the DUT outputs on every falling edge; directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pulp_io_event_queue;

   localparam int N_CH       = 32;
   localparam int N_EVT      = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int TS_WIDTH   = 16;
   localparam int N_SRC      = N_CH * N_EVT;
   localparam int ID_W       = $clog2(N_SRC);
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b1;
   logic [N_CH-1:0][N_EVT-1:0] events;
   logic [N_SRC-1:0]           ev_flat;
   logic [N_SRC-1:0]           mask;
   logic                       clear;
   logic                       ready;
   logic                       evt_valid;
   logic [ID_W-1:0]            evt_id;
   logic [TS_WIDTH-1:0]        evt_ts;
   logic [LVL_W-1:0]           level;
   logic                       ovf;

   int n_checks = 0;
   int n_errors = 0;

   assign ev_flat = events;

   always #5 clk = ~clk;

   pulp_io_event_queue #(
      .N_CH       (N_CH),
      .N_EVT      (N_EVT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TS_WIDTH   (TS_WIDTH)
   ) dut (
      .sys_clk_i    (clk),
      .sys_rst_ni   (rst_n),
      .events_i     (events),
      .evt_mask_i   (mask),
      .clear_i      (clear),
      .evt_valid_o  (evt_valid),
      .evt_id_o     (evt_id),
      .evt_ts_o     (evt_ts),
      .evt_ready_i  (ready),
      .fifo_level_o (level),
      .overflow_o   (ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: pending set, round-robin pointer, ID queue, sticky flag.
   // ---------------------------------------------------------------------------
   bit m_pend [N_SRC];
   int m_rr;
   bit m_ovf;
   int m_q  [$];
   int m_tq [$];
   int m_cnt;

   task automatic model_reset();
      for (int s = 0; s < N_SRC; s++) m_pend[s] = 1'b0;
      m_rr  = 0;
      m_ovf = 1'b0;
      m_q.delete();
      m_tq.delete();
      m_cnt = 0;
   endtask

   task automatic model_step();
      bit pop;
      bit can_push;
      int g;
      pop      = (m_q.size() != 0) && ready;
      can_push = (m_q.size() < FIFO_DEPTH) || pop;
      if (clear) begin
         for (int s = 0; s < N_SRC; s++) m_pend[s] = 1'b0;
         m_rr  = 0;
         m_ovf = 1'b0;
         m_q.delete();
         m_tq.delete();
      end else begin
         g = -1;
         if (can_push) begin
            for (int k = 0; k < N_SRC; k++) begin
               if (g < 0 && m_pend[(m_rr + k) % N_SRC]) g = (m_rr + k) % N_SRC;
            end
         end
         for (int s = 0; s < N_SRC; s++) begin
            if (ev_flat[s] && mask[s] && m_pend[s] && s != g) m_ovf = 1'b1;
         end
         if (pop) begin
            void'(m_q.pop_front());
            void'(m_tq.pop_front());
         end
         if (g >= 0) begin
            m_q.push_back(g);
            m_tq.push_back(m_cnt % (1 << TS_WIDTH));
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % N_SRC;
         end
         for (int s = 0; s < N_SRC; s++) begin
            if (ev_flat[s] && mask[s]) m_pend[s] = 1'b1;
         end
      end
      m_cnt++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Compare process: outputs are checked every cycle outside reset.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("cmp_valid", evt_valid, (m_q.size() != 0));
            chk("cmp_id",    evt_id,    (m_q.size() != 0) ? m_q[0] : 0);
            chk("cmp_level", level,     m_q.size());
            chk("cmp_ovf",   ovf,       m_ovf);
`ifdef PULP_IO_EVT_TIMESTAMP_EN
            chk("cmp_ts",    evt_ts,    (m_tq.size() != 0) ? m_tq[0] : 0);
`else
            chk("cmp_ts",    evt_ts,    0);
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse1(input int s);
      logic [N_SRC-1:0] v;
      v = events;
      v[s] = 1'b1;
      events = v;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      int exp_ids [4] = '{5, 9, 120, 6};
      events = '0;
      mask   = '1;
      clear  = 1'b0;
      ready  = 1'b0;
      #2 rst_n = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", evt_valid, 0);
      chk("rst_id",    evt_id,    0);
      chk("rst_level", level,     0);
      chk("rst_ovf",   ovf,       0);
      chk("rst_ts",    evt_ts,    0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single pulse on channel 2, line 1 -> ID 9, visible two cycles later
      events[2][1] = 1'b1;            // cycle 0
      tick();
      events = '0;                     // cycle 1
      @(negedge clk);
      chk("t1_valid_c1", evt_valid, 0);
      tick();                          // cycle 2
      @(negedge clk);
      chk("t1_valid_c2", evt_valid, 1);
      chk("t1_id",       evt_id,    9);
      chk("t1_level",    level,     1);
`ifdef PULP_IO_EVT_TIMESTAMP_EN
      chk("t1_ts",       evt_ts,    1);
`endif
      ready = 1'b1;
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("t1_pop_level", level, 0);

      // Round-robin order 5, 9, 120, then 6 after wrapping past 127
      do_clear();
      pulse1(5); pulse1(9); pulse1(120);
      tick();
      events = '0;
      repeat (4) tick();
      pulse1(6);
      tick();
      events = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("t2_level", level, 4);
      tick();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_order", evt_id, exp_ids[i]);
         tick();
      end
      ready = 1'b0;
      @(negedge clk);
      chk("t2_empty", level, 0);

      // Fill: ten sources, eight entries, two pending held
      do_clear();
      for (int k = 0; k < 10; k++) pulse1(k * 10);
      tick();
      events = '0;
      repeat (12) tick();
      @(negedge clk);
      chk("t3_full_level", level, 8);
      chk("t3_full_head",  evt_id, 0);
      tick();
      ready = 1'b1;                    // pop 0 and push 80 in the same cycle
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("t3_pushpop_level", level, 8);
      chk("t3_pushpop_head",  evt_id, 10);

      // Repeated pulse on 3 while full -> sticky overflow, then clear
      pulse1(3);
      tick();
      tick();                          // second pulse while pending[3]=1
      events = '0;
      @(negedge clk);
      chk("t4_ovf_set", ovf, 1);
      repeat (3) tick();
      @(negedge clk);
      chk("t4_ovf_sticky", ovf, 1);
      clear = 1'b1;
      pulse1(40);                      // discarded by the clear
      tick();
      clear  = 1'b0;
      events = '0;
      @(negedge clk);
      chk("t4_clr_level", level, 0);
      chk("t4_clr_ovf",   ovf, 0);
      chk("t4_clr_valid", evt_valid, 0);
      repeat (3) tick();
      @(negedge clk);
      chk("t4_clr_discard", evt_valid, 0);

      // Masked source 7 is ignored; re-enabling does not resurrect it
      mask[7] = 1'b0;
      pulse1(7);
      tick();
      events = '0;
      repeat (4) tick();
      @(negedge clk);
      chk("t5_masked_valid", evt_valid, 0);
      mask = '1;
      repeat (3) tick();
      @(negedge clk);
      chk("t5_unmask_valid", evt_valid, 0);

      // Pulse on 7 coincident with its own grant -> queued twice, no overflow
      pulse1(7);                       // cycle A
      tick();                          // cycle A+1: grant 7, pulse again
      tick();                          // cycle A+2
      events = '0;
      tick();                          // cycle A+3
      @(negedge clk);
      chk("t5_twice_level", level, 2);
      chk("t5_twice_id",    evt_id, 7);
      chk("t5_twice_ovf",   ovf, 0);
      tick();
      ready = 1'b1;
      tick();
      @(negedge clk);
      chk("t5_second_id", evt_id, 7);
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("t5_drained", level, 0);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
